stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-channel streaming multiplexer with a valid/ready handshake on every input and on the output. The output stage is registered. Channel selection is either fixed, from a `sel` input, or round-robin arbitration across all valid channels. It sits wherever several producer streams share one consumer, replacing the plain combinational 4:1 mux wherever back-pressure or fair sharing is needed.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels, 2..16.
- `WIDTH`, default 8: data width per channel, ≥1.
- `SW`, default `$clog2(N_CH)`: select/channel-index width. Derived; never overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SW+1  fixed-mode channel index; MSB set or value ≥ N_CH = no channel.
- `in_data`  in  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid`  in  N_CH  per-channel valid.
- `in_ready`  out  N_CH  per-channel ready (combinational).
- `out_data`  out  WIDTH  registered output data.
- `out_ch`  out  SW  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- **Load enable:** `load_en = ~out_valid | out_ready`. The output register can accept a new word this cycle.
- **Grant, fixed mode:** grant = `sel` if `sel < N_CH`, otherwise none. Channels other than `sel` see `in_ready = 0`.
- **Grant, round-robin mode:** the first channel with `in_valid = 1`, searching from `rr_ptr` upward and wrapping modulo N_CH. No valid channel means no grant.
- **In-ready:** `in_ready[k] = load_en & grant_valid & (grant == k) & ~rst`. At most one bit is set per cycle.
- **Transfer on channel g:** occurs when `in_valid[g] & in_ready[g]`. On the clock edge, `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
- **Drain:** if `load_en` is 1 and there is no transfer, `out_valid <= 0`. `out_data` and `out_ch` hold their values.
- **Stall:** if `out_valid & ~out_ready`, all output registers hold and `in_ready` is all-zero.
- **Pointer update, round-robin:** `rr_ptr <= (g == N_CH-1) ? 0 : g+1` only on a transfer in round-robin mode.
- **Pointer in fixed mode:** `rr_ptr` holds. A mode change takes effect the same cycle, with no flush.
- **Boundary cases:**
  - `sel` out of range: behaves like idle, so `out_valid` drains to 0 and nothing is granted.
  - All channels valid in round-robin mode: each channel is served once per N_CH transfers.
  - Single valid channel: it is served every cycle at full rate.
  - `sel` or `mode` changing while stalled: the registered word is unaffected.
- **Reset:** `rst` asserted mid-transfer discards the held word. No partial state survives.

## Timing
- Reset values: `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `rr_ptr = 0`, `in_ready = 0`.
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 word per cycle while `out_ready` is held at 1.
- Path constraints:
  - `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid`, `sel`, `mode` and `rr_ptr`.
  - `out_*` outputs have no combinational path from any input.
- Producer rule: once `in_valid` is asserted, it and `in_data` must stay stable until the handshake. The block does not check this.
- First cycle after `rst` deasserts: a transfer may occur immediately.

## Structure
- **Shared package `stream_mux_pkg`:**
  - `MODE_FIXED = 1'b0` and `MODE_RR = 1'b1`.
  - Function `rr_next(ptr, n)` for the wrap increment.
- **Sub-module `rr_arbiter`:**
  - Parameter `N_CH`.
  - Inputs: `req[N_CH]`, `ptr[SW]`.
  - Outputs: `gnt_idx[SW]`, `gnt_valid`.
  - Purely combinational, using a rotate, priority-encode and un-rotate scheme.
  - Reused by later arbiters.
- **Top level:** `stream_mux_rr` holds the grant mux, `load_en` logic, output register and `rr_ptr`.

## Test plan
- **Reset:** hold `rst` for 3 cycles with all inputs active.
  - Required: `in_ready = 0000`, `out_valid = 0` and `out_data = 00` throughout.
  - Required: the first transfer occurs in the cycle after release.
- **Fixed mode:** `mode = 0`, `sel = 2`, channels 0..3 valid with data 0x10, 0x20, 0x30, 0x40, `out_ready = 1`.
  - Required: `out_data = 0x30` and `out_ch = 2` every cycle.
  - Required: `in_ready = 0100`.
  - Then set `sel = 3'b100`: `out_valid` falls to 0 one cycle later.
- **Round-robin:** `mode = 1`, all 4 channels valid.
  - Required: `out_ch` sequence 0, 1, 2, 3, 0, 1 with `out_valid` continuously high.
  - Then drop channels 1 and 2: sequence becomes 3, 0, 3, 0.
- **Back-pressure:** round-robin, all valid, `out_ready = 0` for 4 cycles after the first word (ch0).
  - Required: `out_data` holds the ch0 value and `in_ready = 0000` during the stall.
  - Required: the next word after release comes from ch1, with no loss or duplication (scoreboard).
- **Mode switch:** mid-stream round-robin with `rr_ptr = 2`, switch to fixed `sel = 0` for 3 transfers, then back to round-robin.
  - Required: the next round-robin grant is ch2, since the pointer was preserved.
- **Mid-operation reset:** `rst` pulsed while `out_valid = 1` and stalled.
  - Required: `out_valid = 0` next cycle and `rr_ptr` back to 0, so the next round-robin grant is ch0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream multiplexer family: mode encodings and
// the round-robin pointer wrap helper.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Advance a channel pointer by one, wrapping to zero after the last channel
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick the lowest
// set bit, then un-rotate to recover the absolute channel index.
module rr_arbiter #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] ptr,
  output logic [$clog2(N_CH)-1:0] gnt_idx,
  output logic                    gnt_valid
);

  localparam int unsigned SW = $clog2(N_CH);

  logic [2*N_CH-1:0] req_dbl;
  logic [2*N_CH-1:0] req_shift;
  logic [N_CH-1:0]   req_rot;
  logic [SW-1:0]     enc;
  logic [SW:0]       idx_sum;

  // Doubling the vector turns the rotate into a plain right shift
  always_comb begin
    req_dbl   = {req, req};
    req_shift = req_dbl >> ptr;
    req_rot   = req_shift[N_CH-1:0];
  end

  always_comb begin
    enc       = '0;
    gnt_valid = |req_rot;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) enc = SW'(i);
    end
  end

  always_comb begin
    idx_sum = {1'b0, enc} + {1'b0, ptr};
    if (idx_sum >= (SW+1)'(N_CH)) idx_sum = idx_sum - (SW+1)'(N_CH);
    gnt_idx = idx_sum[SW-1:0];
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage;
// channel chosen by a fixed select or by round-robin arbitration.
module stream_mux_rr #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SW    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SW:0]           sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  import stream_mux_pkg::*;

  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    arb_idx;
  logic             arb_valid;
  logic             load_en_c;
  logic [SW-1:0]    grant_c;
  logic             grant_valid_c;
  logic             xfer_c;
  logic [WIDTH-1:0] grant_data_c;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign load_en_c = ~out_valid | out_ready;

  // Fixed mode grants sel whenever it names a real channel, valid or not
  always_comb begin
    grant_c       = '0;
    grant_valid_c = 1'b0;
    if (mode == MODE_RR) begin
      grant_c       = arb_idx;
      grant_valid_c = arb_valid;
    end else if (sel < (SW+1)'(N_CH)) begin
      grant_c       = sel[SW-1:0];
      grant_valid_c = 1'b1;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      in_ready[k] = load_en_c & grant_valid_c & ~rst & (grant_c == SW'(k));
    end
  end

  assign xfer_c = |(in_valid & in_ready);

  always_comb begin
    grant_data_c = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_c == SW'(k)) grant_data_c = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer; stalls hold everything
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load_en_c) begin
      if (xfer_c) begin
        out_valid <= 1'b1;
        out_data  <= grant_data_c;
        out_ch    <= grant_c;
        if (mode == MODE_RR) rr_ptr <= SW'(rr_next(32'(grant_c), N_CH));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr with 4 channels of 8 bits.
module tb_stream_mux_rr;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned SW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mode;
  logic [SW:0]           sel;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SW-1:0]         out_ch;
  logic                  out_valid;
  logic                  out_ready;

  int vectors     = 0;
  int miscompares = 0;

  stream_mux_rr #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] ch, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".ch"},    32'(out_ch),    32'(ch));
    chk({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 1'b1;
    sel       = 3'd0;
    in_data   = {8'h40, 8'h30, 8'h20, 8'h10};
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Reset held three cycles with all inputs active
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.in_ready", 32'(in_ready), 32'h0);
      chk_out("rst", 1'b0, 2'd0, 8'h00);
    end
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_out("rel.first", 1'b1, 2'd0, 8'h10);

    // Fixed select of channel 2
    mode = 1'b0;
    sel  = 3'd2;
    #1;
    chk("fix.in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("fix.w0", 1'b1, 2'd2, 8'h30);
    chk("fix.in_ready1", 32'(in_ready), 32'b0100);
    tick();
    chk_out("fix.w1", 1'b1, 2'd2, 8'h30);
    sel = 3'b100;
    #1;
    chk("fix.oor.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("fix.oor.valid", 32'(out_valid), 32'h0);
    chk("fix.oor.hold", 32'(out_data), 32'h30);

    // Round-robin from a fresh pointer
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    mode = 1'b1;
    tick();
    chk_out("rr.s0", 1'b1, 2'd0, 8'h10);
    tick();
    chk_out("rr.s1", 1'b1, 2'd1, 8'h20);
    tick();
    chk_out("rr.s2", 1'b1, 2'd2, 8'h30);
    tick();
    chk_out("rr.s3", 1'b1, 2'd3, 8'h40);
    tick();
    chk_out("rr.s4", 1'b1, 2'd0, 8'h10);
    tick();
    chk_out("rr.s5", 1'b1, 2'd1, 8'h20);
    in_valid = 4'b1001;
    tick();
    chk_out("rr.d0", 1'b1, 2'd3, 8'h40);
    tick();
    chk_out("rr.d1", 1'b1, 2'd0, 8'h10);
    tick();
    chk_out("rr.d2", 1'b1, 2'd3, 8'h40);
    tick();
    chk_out("rr.d3", 1'b1, 2'd0, 8'h10);

    // Back-pressure after the first word
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b1111;
    tick();
    chk_out("bp.first", 1'b1, 2'd0, 8'h10);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp.in_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("bp.hold", 1'b1, 2'd0, 8'h10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.rel.in_ready", 32'(in_ready), 32'b0010);
    tick();
    chk_out("bp.next", 1'b1, 2'd1, 8'h20);

    // Pointer now 2: three fixed transfers on ch0, then back to round-robin
    mode = 1'b0;
    sel  = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("ms.fixed", 1'b1, 2'd0, 8'h10);
    end
    mode = 1'b1;
    #1;
    chk("ms.in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("ms.resume", 1'b1, 2'd2, 8'h30);

    // Stall, switch sel/mode while stalled, then reset mid-transfer
    out_ready = 1'b0;
    tick();
    mode = 1'b0;
    sel  = 3'd1;
    tick();
    chk_out("mr.stall", 1'b1, 2'd2, 8'h30);
    mode = 1'b1;
    rst  = 1'b1;
    #1;
    chk("mr.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("mr.rst", 1'b0, 2'd0, 8'h00);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mr.rel.in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_out("mr.first", 1'b1, 2'd0, 8'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
